// File: rtl/keypad_scan_debounce.sv
// rtl/keypad_scan_debounce.sv - 4x4 keypad column scanner with frame-level debounce
module keypad_scan_debounce #(
    parameter int SCAN_DIV     = 50000,
    parameter int DEBOUNCE_CNT = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam int DW = $clog2(SCAN_DIV);
    localparam int CW = $clog2(DEBOUNCE_CNT + 1);

    typedef enum logic [1:0] {IDLE, CAND, PRESSED, REL} state_t;

    logic [3:0]    row_m, row_s;
    logic [DW-1:0] div;
    logic [1:0]    col_idx;
    logic [1:0]    acc_n;
    logic [3:0]    acc_code;
    state_t        state;
    logic [3:0]    cand;
    logic [CW-1:0] cnt;

    logic          sample, frame_end;
    logic [1:0]    col_n, hit_row, tot_n;
    logic [2:0]    sum_n;
    logic [3:0]    fcode;
    logic          f_single, f_none;

    function automatic logic [3:0] keymap(input logic [1:0] c, input logic [1:0] r);
        logic [3:0] k;
        case ({c, r})
            4'h0: k = 4'h1; 4'h1: k = 4'h4; 4'h2: k = 4'h7; 4'h3: k = 4'h0;
            4'h4: k = 4'h2; 4'h5: k = 4'h5; 4'h6: k = 4'h8; 4'h7: k = 4'hF;
            4'h8: k = 4'h3; 4'h9: k = 4'h6; 4'hA: k = 4'h9; 4'hB: k = 4'hE;
            default: k = 4'hA + 4'(r);
        endcase
        return k;
    endfunction

    assign col       = ~(4'b0001 << col_idx);
    assign sample    = (div == DW'(SCAN_DIV - 1));
    assign frame_end = sample && (col_idx == 2'd3);

    // acc_n / col_n saturate at 2: anything beyond one low bit is already a ghost
    always_comb begin
        col_n   = 2'd0;
        hit_row = 2'd0;
        for (int r = 0; r < 4; r++) begin
            if (!row_s[r]) begin
                hit_row = 2'(r);
                if (col_n != 2'd2) col_n = col_n + 2'd1;
            end
        end
        sum_n    = {1'b0, acc_n} + {1'b0, col_n};
        tot_n    = (sum_n >= 3'd2) ? 2'd2 : sum_n[1:0];
        fcode    = (acc_n != 2'd0) ? acc_code : keymap(col_idx, hit_row);
        f_single = (tot_n == 2'd1);
        f_none   = (tot_n == 2'd0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_m    <= 4'hF;
            row_s    <= 4'hF;
            div      <= '0;
            col_idx  <= 2'd0;
            acc_n    <= 2'd0;
            acc_code <= 4'h0;
        end else begin
            row_m <= row;
            row_s <= row_m;
            if (sample) begin
                div      <= '0;
                col_idx  <= col_idx + 2'd1;
                acc_n    <= frame_end ? 2'd0 : tot_n;
                acc_code <= fcode;
            end else begin
                div <= div + DW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cand      <= 4'h0;
            cnt       <= '0;
            key_code  <= 4'h0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
        end else begin
            key_valid <= 1'b0;
            if (frame_end) begin
                case (state)
                    IDLE: begin
                        if (f_single) begin
                            cand <= fcode;
                            cnt  <= CW'(1);
                            if (DEBOUNCE_CNT == 1) begin
                                state     <= PRESSED;
                                key_code  <= fcode;
                                key_valid <= 1'b1;
                                key_held  <= 1'b1;
                            end else begin
                                state <= CAND;
                            end
                        end
                    end
                    CAND: begin
                        if (f_single && fcode == cand) begin
                            if (cnt >= CW'(DEBOUNCE_CNT - 1)) begin
                                cnt       <= CW'(DEBOUNCE_CNT);
                                state     <= PRESSED;
                                key_code  <= cand;
                                key_valid <= 1'b1;
                                key_held  <= 1'b1;
                            end else begin
                                cnt <= cnt + CW'(1);
                            end
                        end else if (f_single) begin
                            cand <= fcode;
                            cnt  <= CW'(1);
                        end else begin
                            state <= IDLE;
                            cnt   <= '0;
                        end
                    end
                    PRESSED: begin
                        if (f_none) begin
                            if (DEBOUNCE_CNT == 1) begin
                                state    <= IDLE;
                                cnt      <= '0;
                                key_held <= 1'b0;
                            end else begin
                                state <= REL;
                                cnt   <= CW'(1);
                            end
                        end
                    end
                    default: begin
                        if (!f_none) begin
                            state <= PRESSED;
                        end else if (cnt >= CW'(DEBOUNCE_CNT - 1)) begin
                            state    <= IDLE;
                            cnt      <= '0;
                            key_held <= 1'b0;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_keypad_scan_debounce.sv
// tb/tb_keypad_scan_debounce.sv - randomized frame-level check of keypad_scan_debounce
module tb_keypad_scan_debounce;

    localparam int SD = 4;
    localparam int DC = 2;
    localparam int FRAME = 4 * SD;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] row;
    logic [3:0] col;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;
    logic [15:0] pressed;

    int n_cmp = 0;
    int n_err = 0;

    // reference model state: frame-history counters, not the DUT encoding
    int   m_cand, m_run, m_rel;
    logic m_held;
    logic [3:0] m_code;
    logic m_valid;

    keypad_scan_debounce #(.SCAN_DIV(SD), .DEBOUNCE_CNT(DC)) dut (
        .clk(clk), .rst(rst), .row(row), .col(col),
        .key_code(key_code), .key_valid(key_valid), .key_held(key_held)
    );

    always #5 clk = ~clk;

    function automatic int key_col(input int k);
        case (k)
            1, 4, 7, 0:      return 0;
            2, 5, 8, 15:     return 1;
            3, 6, 9, 14:     return 2;
            default:         return 3;
        endcase
    endfunction

    function automatic int key_row(input int k);
        case (k)
            1, 2, 3, 10:     return 0;
            4, 5, 6, 11:     return 1;
            7, 8, 9, 12:     return 2;
            default:         return 3;
        endcase
    endfunction

    always_comb begin
        row = 4'hF;
        for (int k = 0; k < 16; k++)
            if (pressed[k] && !col[key_col(k)]) row[key_row(k)] = 1'b0;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_cand = -1; m_run = 0; m_rel = 0; m_held = 1'b0; m_code = 4'h0; m_valid = 1'b0;
    endtask

    task automatic model_frame(input logic [15:0] keys);
        int n, k;
        n = $countones(keys);
        k = 0;
        for (int i = 0; i < 16; i++) if (keys[i]) k = i;
        m_valid = 1'b0;
        if (!m_held) begin
            if (n == 1) begin
                if (m_run > 0 && k == m_cand) m_run++;
                else begin m_cand = k; m_run = 1; end
                if (m_run >= DC) begin
                    m_valid = 1'b1; m_code = 4'(k); m_held = 1'b1; m_rel = 0;
                end
            end else begin
                m_run = 0;
            end
        end else if (n == 0) begin
            m_rel++;
            if (m_rel >= DC) begin m_held = 1'b0; m_run = 0; end
        end else begin
            m_rel = 0;
        end
    endtask

    task automatic run_frame(input logic [15:0] keys);
        int stray;
        logic [3:0] ecol;
        logic [3:0] one;
        pressed = keys;
        model_frame(keys);
        stray = 0;
        one = 4'b0001;
        for (int i = 1; i <= FRAME; i++) begin
            @(negedge clk);
            ecol = ~(one << ((i / SD) % 4));
            chk("col", col, ecol);
            if (i < FRAME && key_valid) stray++;
        end
        chk("stray_valid", stray, 0);
        chk("valid", key_valid, m_valid);
        chk("held", key_held, m_held);
        chk("code", key_code, m_code);
    endtask

    task automatic repeat_frames(input logic [15:0] keys, input int n);
        for (int i = 0; i < n; i++) run_frame(keys);
    endtask

    task automatic mid_reset(input int cycles);
        repeat (cycles) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_col", col, 4'b1110);
        chk("rst_held", key_held, 0);
        chk("rst_valid", key_valid, 0);
        chk("rst_code", key_code, 0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    function automatic logic [15:0] km(input int k);
        logic [15:0] one;
        one = 16'h0001;
        return one << k;
    endfunction

    initial begin
        int cur, r;
        logic [15:0] keys;
        rst = 1'b1;
        pressed = 16'h0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("reset_col", col, 4'b1110);
        chk("reset_code", key_code, 0);
        chk("reset_valid", key_valid, 0);
        chk("reset_held", key_held, 0);
        rst = 1'b0;

        repeat_frames(16'h0, 2);
        repeat_frames(km(5), 3);
        repeat_frames(16'h0, 3);
        run_frame(km(9));
        repeat_frames(16'h0, 2);
        repeat_frames(km(1) | km(2), 4);
        repeat_frames(km(1), 3);
        repeat_frames(16'h0, 3);
        repeat_frames(km(13), 10);
        repeat_frames(16'h0, 3);
        repeat_frames(km(13), 3);
        repeat_frames(16'h0, 3);

        run_frame(km(10));
        pressed = km(10);
        mid_reset(7);
        repeat_frames(km(10), 3);
        repeat_frames(16'h0, 3);

        cur = 0;
        for (int f = 0; f < 120; f++) begin
            r = $urandom_range(0, 9);
            if (r < 3) begin
                keys = 16'h0;
            end else if (r < 9) begin
                if ($urandom_range(0, 3) == 0) cur = $urandom_range(0, 15);
                keys = km(cur);
            end else begin
                keys = km(cur) | km((cur + 1 + $urandom_range(0, 14)) % 16);
            end
            run_frame(keys);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
